// File: rtl/iter_cmp.sv
// rtl/iter_cmp.sv - multi-cycle sliced magnitude comparator, signed/unsigned, start/busy/done
module iter_cmp #(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             great,
    output logic             less
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0]    LAST     = KW'(NCHUNK - 1);
    // Flipping the sign bit of both operands maps two's-complement order onto unsigned order
    localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [KW-1:0]    k;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic             decided;

    // Select slice k, counting from the most significant end
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (k == KW'(i)) begin
                a_sl = a_r[WIDTH-1-i*CHUNK -: CHUNK];
                b_sl = b_r[WIDTH-1-i*CHUNK -: CHUNK];
            end
        end
    end

    // Once great or less is set, later slices cannot change the outcome
    always_comb decided = great | less;

    // Handshake and slice-walk state machine with registered result flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            equal <= 1'b0;
            great <= 1'b0;
            less  <= 1'b0;
            k     <= '0;
            a_r   <= '0;
            b_r   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= signed_mode ? (A ^ SIGN_BIT) : A;
                        b_r   <= signed_mode ? (B ^ SIGN_BIT) : B;
                        equal <= 1'b0;
                        great <= 1'b0;
                        less  <= 1'b0;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!decided && (a_sl != b_sl)) begin
                        great <= (a_sl > b_sl);
                        less  <= (a_sl < b_sl);
                        if ((EARLY_EXIT != 0) || (k == LAST)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end else if (k == LAST) begin
                        if (!decided) begin
                            equal <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
